// File: rtl/ram_pkg.sv
// Shared constants and types for the two-port RAM arbiter and its RAM.
package ram_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;

    // Identifies one of the two requesters.
    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM: one access per cycle while en is high.
// A read returns its data on dataout one cycle after the access edge;
// dataout holds its value on writes and idle cycles. Contents are not reset.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] datain,
    output logic [DATA_WIDTH-1:0] dataout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dataout_q;

    // Storage array and registered read port; writes land before any later read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wr) begin
                mem_q[addr] <= datain;
            end else begin
                dataout_q <= mem_q[addr];
            end
        end
    end

    assign dataout = dataout_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single RAM. Grants are combinational
// from the requests and a 1-bit priority pointer that points at whoever lost
// the last grant, so contending requesters alternate cycle by cycle. Read
// responses come back one cycle after the grant on the granted port.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1
);

    req_id_t               prio_q, prio_d;
    logic                  rd_pend_q, rd_pend_d;
    req_id_t               rd_id_q, rd_id_d;

    logic                  ram_en;
    logic                  ram_wr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_datain;
    logic [DATA_WIDTH-1:0] ram_dataout;

    // Grant selection: a lone requester wins outright, a tie goes to prio.
    // Reset forces both grants low so nothing reaches the RAM.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0 && req1) begin
                gnt0 = (prio_q == REQ0);
                gnt1 = (prio_q == REQ1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // RAM request mux from the granted requester; address passes through as-is.
    always_comb begin
        ram_en     = gnt0 | gnt1;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_datain = '0;
        if (gnt1) begin
            ram_wr     = wr1;
            ram_addr   = addr1;
            ram_datain = wdata1;
        end else if (gnt0) begin
            ram_wr     = wr0;
            ram_addr   = addr0;
            ram_datain = wdata0;
        end
    end

    // Next-state for the priority pointer and the read-response tracker.
    always_comb begin
        prio_d    = prio_q;
        rd_pend_d = ram_en & ~ram_wr;
        rd_id_d   = rd_id_q;
        if (gnt0) begin
            prio_d  = REQ1;
            rd_id_d = REQ0;
        end else if (gnt1) begin
            prio_d  = REQ0;
            rd_id_d = REQ1;
        end
    end

    // Control state; reset drops any read response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= REQ0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= REQ0;
        end else begin
            prio_q    <= prio_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign rvalid0 = rd_pend_q & (rd_id_q == REQ0);
    assign rvalid1 = rd_pend_q & (rd_id_q == REQ1);
    assign rdata0  = ram_dataout;
    assign rdata1  = ram_dataout;

    ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .en      (ram_en),
        .wr      (ram_wr),
        .addr    (ram_addr),
        .datain  (ram_datain),
        .dataout (ram_dataout)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with hand-computed expectations.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, wr0, wr1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] wtbl [8] = '{8'h5A, 8'h11, 8'hC3, 8'h7E, 8'h80, 8'h01, 8'hFF, 8'h96};

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .wr0     (wr0),
        .wr1     (wr1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [2:0] a1, input logic [7:0] d1);
        req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        // Requests asserted during reset must not be granted.
        drive(1'b1, 1'b1, 3'd0, 8'h10, 1'b1, 1'b1, 3'd1, 8'h11);
        tick();
        #1;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_prio", 32'(dut.prio_q), 32'd0);
        tick();
        rst_n = 1'b1;

        // Contention right after reset: writes from both sides, held 4 cycles.
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_gnt0_%0d", i), 32'(gnt0), 32'((i % 2) == 0));
            check($sformatf("cont_gnt1_%0d", i), 32'(gnt1), 32'((i % 2) == 1));
            check($sformatf("cont_rvalid_%0d", i), 32'({rvalid0, rvalid1}), 32'd0);
            tick();
        end
        idle();
        #1;
        check("cont_prio", 32'(dut.prio_q), 32'd0);
        check("cont_idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        tick();

        // Single requester write then read of address 5.
        drive(1'b1, 1'b1, 3'd5, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        check("sw_wr_gnt0", 32'(gnt0), 32'd1);
        tick();
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        check("sw_rd_gnt0", 32'(gnt0), 32'd1);
        check("sw_wr_no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        tick();
        idle();
        #1;
        check("sw_rvalid0", 32'(rvalid0), 32'd1);
        check("sw_rvalid1", 32'(rvalid1), 32'd0);
        check("sw_rdata0", 32'(rdata0), 32'hA5);
        tick();
        #1;
        check("sw_rvalid0_pulse", 32'(rvalid0), 32'd0);

        // Cross-port coherence: req1 writes addr 2, req0 reads it next cycle.
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd2, 8'h3C);
        #1;
        check("xp_wr_gnt", 32'({gnt0, gnt1}), 32'b01);
        tick();
        drive(1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        check("xp_rd_gnt", 32'({gnt0, gnt1}), 32'b10);
        tick();
        idle();
        #1;
        check("xp_rvalid", 32'({rvalid0, rvalid1}), 32'b10);
        check("xp_rdata0", 32'(rdata0), 32'h3C);
        check("xp_prio", 32'(dut.prio_q), 32'd1);
        tick();

        // Lone requester 1 held for 3 cycles.
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h77);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lone_gnt_%0d", i), 32'({gnt0, gnt1}), 32'b01);
            tick();
        end
        idle();
        #1;
        check("lone_prio", 32'(dut.prio_q), 32'd0);
        tick();

        // Write stream to all 8 addresses from req0.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'(i), wtbl[i], 1'b0, 1'b0, 3'd0, 8'h00);
            #1;
            check($sformatf("ws_gnt0_%0d", i), 32'(gnt0), 32'd1);
            check($sformatf("ws_rvalid_%0d", i), 32'({rvalid0, rvalid1}), 32'd0);
            tick();
        end
        // Back-to-back read-back: each rvalid overlaps the next grant.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'(i), 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
            #1;
            check($sformatf("rb_gnt0_%0d", i), 32'(gnt0), 32'd1);
            if (i > 0) begin
                check($sformatf("rb_rvalid_%0d", i - 1), 32'({rvalid0, rvalid1}), 32'b10);
                check($sformatf("rb_rdata_%0d", i - 1), 32'(rdata0), 32'(wtbl[i - 1]));
            end
            tick();
        end
        idle();
        #1;
        check("rb_rvalid_7", 32'({rvalid0, rvalid1}), 32'b10);
        check("rb_rdata_7", 32'(rdata0), 32'(wtbl[7]));
        check("rb_prio", 32'(dut.prio_q), 32'd1);
        tick();

        // Reset mid-read: req1 read granted, reset before its response edge.
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
        #1;
        check("mr_gnt1", 32'({gnt0, gnt1}), 32'b01);
        tick();
        drive(1'b1, 1'b1, 3'd0, 8'h21, 1'b1, 1'b1, 3'd1, 8'h22);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid_drop", 32'({rvalid0, rvalid1}), 32'd0);
        check("mr_gnt_forced", 32'({gnt0, gnt1}), 32'd0);
        check("mr_prio", 32'(dut.prio_q), 32'd0);
        tick();
        #1;
        check("mr_rvalid_hold", 32'({rvalid0, rvalid1}), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mr_first_gnt", 32'({gnt0, gnt1}), 32'b10);
        check("mr_post_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        tick();
        #1;
        check("mr_second_gnt", 32'({gnt0, gnt1}), 32'b01);
        check("mr_post_rvalid2", 32'({rvalid0, rvalid1}), 32'd0);
        tick();
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
